// File: rtl/dual_port_ram.sv
// dual_port_ram
//   Simple dual-port RAM: one synchronous write port, one registered read port.
//   The read data register gives a fixed 1-cycle read latency and holds its
//   value while read_en is low. Only the read register is reset; the storage
//   array is not.
// Ports:
//   write_clock            write port clock
//   write_addr/en/data     write port
//   read_clock             read port clock
//   read_rst_n             async active-low reset of the read data register
//   read_addr/en           read port request
//   read_data              registered read data
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  write_clock,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_clock,
  input  logic                  read_rst_n,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge write_clock) begin
    if (write_en) r_mem[write_addr] <= write_data;
  end

  always_ff @(posedge read_clock or negedge read_rst_n) begin
    if (!read_rst_n)  read_data <= '0;
    else if (read_en) read_data <= r_mem[read_addr];
  end
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with standard (registered) or first-word-fall-through
//   read mode, occupancy count, almost-full/almost-empty thresholds,
//   synchronous flush and sticky overflow/underflow flags.
// Handshake: a write is accepted when req_w=1 and full=0; a read (FWFT: pop of
//   the head word) is accepted when req_r=1 and empty=0. Both decisions use the
//   registered flags of the current cycle. Rejected requests set the sticky
//   error flags; flush overrides both requests and sets no error.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   flush                     synchronous empty request
//   data_w, req_w             write data / request
//   full, almost_full         write-side status
//   data_r, req_r             read data / request (acknowledge in FWFT)
//   empty, almost_empty       read-side status
//   count                     words held, 0..DEPTH
//   overflow, underflow       sticky error flags
module sync_fifo_flags #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic                  req_w,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_r,
  input  logic                  req_r,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY_LEVEL);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  generate
    if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: ALMOST_FULL_LEVEL out of range 1..DEPTH");
    end
    if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: ALMOST_EMPTY_LEVEL out of range 0..DEPTH-1");
    end
  endgenerate

  logic [PW-1:0]         r_wptr, r_rptr, r_count, w_count_next;
  logic                  r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic                  w_we, w_re, w_ram_re, w_empty_next, w_ram_has_data;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_we = req_w & ~r_full  & ~flush;
  assign w_re = req_r & ~r_empty & ~flush;
  // RAM holds unread words; the wrap bit separates all-full from all-empty.
  assign w_ram_has_data = (r_wptr != r_rptr);

  always_comb begin
    w_count_next = r_count;
    if (flush)            w_count_next = '0;
    else if (w_we && !w_re) w_count_next = r_count + ONE_C;
    else if (!w_we && w_re) w_count_next = r_count - ONE_C;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_full   <= (w_count_next == DEPTH_C);
      r_empty  <= w_empty_next;
      r_afull  <= (w_count_next >= AF_C);
      r_aempty <= (w_count_next <= AE_C);
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovf  <= 1'b0;
        r_unf  <= 1'b0;
      end else begin
        if (w_we)     r_wptr <= r_wptr + ONE_C;
        if (w_ram_re) r_rptr <= r_rptr + ONE_C;
        if (req_w && r_full)  r_ovf <= 1'b1;
        if (req_r && r_empty) r_unf <= 1'b1;
      end
    end
  end

  dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .write_clock (clk),
    .write_addr  (r_wptr[ADDR_WIDTH-1:0]),
    .write_en    (w_we),
    .write_data  (data_w),
    .read_clock  (clk),
    .read_rst_n  (reset_n),
    .read_addr   (r_rptr[ADDR_WIDTH-1:0]),
    .read_en     (w_ram_re),
    .read_data   (w_ram_q)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Two-stage pipeline after the RAM: the RAM read register (r_q_vld)
      // and the output register (r_o_vld). A RAM read is issued whenever the
      // RAM stage is free or drains this cycle, so pops stream without bubbles.
      logic                  r_q_vld, r_o_vld, w_move, w_o_vld_next;
      logic [DATA_WIDTH-1:0] r_odata;

      assign w_move   = r_q_vld & (~r_o_vld | w_re);
      assign w_ram_re = ~flush & w_ram_has_data & (~r_q_vld | w_move);

      always_comb begin
        w_o_vld_next = r_o_vld;
        if (flush)       w_o_vld_next = 1'b0;
        else if (w_move) w_o_vld_next = 1'b1;
        else if (w_re)   w_o_vld_next = 1'b0;
      end
      assign w_empty_next = ~w_o_vld_next;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_q_vld <= 1'b0;
          r_o_vld <= 1'b0;
          r_odata <= '0;
        end else begin
          r_o_vld <= w_o_vld_next;
          if (flush) r_q_vld <= 1'b0;
          else       r_q_vld <= w_ram_re | (r_q_vld & ~w_move);
          if (!flush && w_move) r_odata <= w_ram_q;
        end
      end
      assign data_r = r_odata;
    end else begin : g_std
      // count==0 and equal pointers coincide here; gating on the pointers
      // keeps the RAM read port idle if the two ever disagreed.
      assign w_ram_re     = w_re & w_ram_has_data;
      assign w_empty_next = (w_count_next == '0);
      assign data_r       = w_ram_q;
    end
  endgenerate

  assign full         = r_full;
  assign almost_full  = r_afull;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       req_w = 1'b0;
  logic       req_r = 1'b0;
  logic [7:0] data_w = 8'h00;

  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
  logic [7:0] s_data_r;
  logic [4:0] s_count;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
  logic [7:0] f_data_r;
  logic [4:0] f_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] s_exp_q[$];
  logic [7:0] f_exp_q[$];
  logic       s_pend = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_std (
    .clk(clk), .reset_n(reset_n), .flush(flush), .data_w(data_w), .req_w(req_w),
    .full(s_full), .almost_full(s_af), .data_r(s_data_r), .req_r(req_r),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush), .data_w(data_w), .req_w(req_w),
    .full(f_full), .almost_full(f_af), .data_r(f_data_r), .req_r(req_r),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [7:0] d);
    s_exp_q.push_back(d);
    f_exp_q.push_back(d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_count"}, 32'(s_count), 0);
    chk({tag, "_s_empty"}, 32'(s_empty), 1);
    chk({tag, "_s_ae"},    32'(s_ae), 1);
    chk({tag, "_s_full"},  32'(s_full), 0);
    chk({tag, "_s_af"},    32'(s_af), 0);
    chk({tag, "_s_ovf"},   32'(s_ovf), 0);
    chk({tag, "_s_unf"},   32'(s_unf), 0);
    chk({tag, "_s_data"},  32'(s_data_r), 0);
    chk({tag, "_f_count"}, 32'(f_count), 0);
    chk({tag, "_f_empty"}, 32'(f_empty), 1);
    chk({tag, "_f_ae"},    32'(f_ae), 1);
    chk({tag, "_f_full"},  32'(f_full), 0);
    chk({tag, "_f_af"},    32'(f_af), 0);
    chk({tag, "_f_ovf"},   32'(f_ovf), 0);
    chk({tag, "_f_unf"},   32'(f_unf), 0);
    chk({tag, "_f_data"},  32'(f_data_r), 0);
  endtask

  // Monitor: standard mode shows read data one edge after an accepted read;
  // FWFT mode shows the head word while it is being popped.
  always @(negedge clk) begin
    if (!reset_n) begin
      s_pend = 1'b0;
    end else begin
      if (s_pend) begin
        checks++;
        if (s_exp_q.size() == 0) begin
          errors++;
          $display("FAIL std_rd_data got %0h expected <none>", s_data_r);
        end else begin
          logic [7:0] e;
          e = s_exp_q.pop_front();
          if (s_data_r !== e) begin
            errors++;
            $display("FAIL std_rd_data got %0h expected %0h at %0t", s_data_r, e, $time);
          end
        end
      end
      s_pend = req_r & ~s_empty & ~flush;
      if (req_r && !f_empty && !flush) begin
        checks++;
        if (f_exp_q.size() == 0) begin
          errors++;
          $display("FAIL fwft_rd_data got %0h expected <none>", f_data_r);
        end else begin
          logic [7:0] e;
          e = f_exp_q.pop_front();
          if (f_data_r !== e) begin
            errors++;
            $display("FAIL fwft_rd_data got %0h expected %0h at %0t", f_data_r, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    step();
    step();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    step();

    // fill 16 words, overflow on the 17th
    for (int i = 0; i < 16; i++) begin
      data_w = 8'(i);
      req_w = 1'b1;
      push_both(8'(i));
      step();
      if (i == 1)  begin chk("ae_at2_s", 32'(s_ae), 1); chk("ae_at2_f", 32'(f_ae), 1); end
      if (i == 2)  begin chk("ae_at3_s", 32'(s_ae), 0); chk("ae_at3_f", 32'(f_ae), 0); end
      if (i == 12) begin chk("af_at13_s", 32'(s_af), 0); chk("af_at13_f", 32'(f_af), 0); end
      if (i == 13) begin chk("af_at14_s", 32'(s_af), 1); chk("af_at14_f", 32'(f_af), 1); end
      if (i == 14) begin chk("full_at15_s", 32'(s_full), 0); chk("full_at15_f", 32'(f_full), 0); end
    end
    chk("full16_s", 32'(s_full), 1);
    chk("count16_s", 32'(s_count), 16);
    chk("full16_f", 32'(f_full), 1);
    chk("count16_f", 32'(f_count), 16);
    data_w = 8'hFF;
    step();
    req_w = 1'b0;
    chk("ovf_s", 32'(s_ovf), 1);
    chk("ovf_f", 32'(f_ovf), 1);
    chk("count_ovf_s", 32'(s_count), 16);
    chk("count_ovf_f", 32'(f_count), 16);

    // drain 16 words, then underflow
    for (int i = 0; i < 16; i++) begin
      req_r = 1'b1;
      step();
      if (i == 0) begin chk("full_fall_s", 32'(s_full), 0); chk("full_fall_f", 32'(f_full), 0); end
    end
    chk("empty_drain_s", 32'(s_empty), 1);
    chk("empty_drain_f", 32'(f_empty), 1);
    chk("count_drain_s", 32'(s_count), 0);
    step();
    req_r = 1'b0;
    chk("unf_s", 32'(s_unf), 1);
    chk("unf_f", 32'(f_unf), 1);
    chk("ovf_sticky_s", 32'(s_ovf), 1);
    chk("ovf_sticky_f", 32'(f_ovf), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf_s", 32'(s_ovf), 0);
    chk("flush_unf_s", 32'(s_unf), 0);
    chk("flush_ovf_f", 32'(f_ovf), 0);
    chk("flush_unf_f", 32'(f_unf), 0);

    // single write: FWFT latency 2, standard empty falls after 1
    data_w = 8'hA5;
    req_w = 1'b1;
    push_both(8'hA5);
    step();
    req_w = 1'b0;
    chk("wr1_empty_s", 32'(s_empty), 0);
    chk("wr1_empty_f", 32'(f_empty), 1);
    chk("wr1_count_f", 32'(f_count), 1);
    step();
    chk("wr2_empty_f", 32'(f_empty), 1);
    step();
    chk("wr3_empty_f", 32'(f_empty), 0);
    chk("wr3_data_f", 32'(f_data_r), 32'h A5);
    req_r = 1'b1;
    step();
    req_r = 1'b0;
    chk("rd1_empty_s", 32'(s_empty), 1);
    chk("rd1_empty_f", 32'(f_empty), 1);
    step();

    // steady state at count 5 with a write and a read every cycle
    for (int i = 0; i < 5; i++) begin
      data_w = 8'(8'h20 + i);
      req_w = 1'b1;
      push_both(8'(8'h20 + i));
      step();
    end
    req_w = 1'b0;
    step();
    step();
    chk("cnt5_s", 32'(s_count), 5);
    chk("cnt5_f", 32'(f_count), 5);
    chk("cnt5_empty_f", 32'(f_empty), 0);
    for (int i = 0; i < 40; i++) begin
      data_w = 8'(8'h25 + i);
      req_w = 1'b1;
      req_r = 1'b1;
      push_both(8'(8'h25 + i));
      step();
      if (i == 20) begin chk("cnt_mid_s", 32'(s_count), 5); chk("cnt_mid_f", 32'(f_count), 5); end
    end
    req_w = 1'b0;
    req_r = 1'b0;
    chk("cnt_rw_s", 32'(s_count), 5);
    chk("cnt_rw_f", 32'(f_count), 5);
    chk("err_rw_s", {30'd0, s_ovf, s_unf}, 0);
    chk("err_rw_f", {30'd0, f_ovf, f_unf}, 0);

    // flush at count 9 together with both requests
    for (int i = 0; i < 4; i++) begin
      data_w = 8'(8'h60 + i);
      req_w = 1'b1;
      push_both(8'(8'h60 + i));
      step();
    end
    req_w = 1'b0;
    chk("cnt9_s", 32'(s_count), 9);
    chk("cnt9_f", 32'(f_count), 9);
    flush = 1'b1;
    req_w = 1'b1;
    req_r = 1'b1;
    data_w = 8'hEE;
    step();
    flush = 1'b0;
    req_r = 1'b0;
    s_exp_q.delete();
    f_exp_q.delete();
    chk("fl_cnt_s", 32'(s_count), 0);
    chk("fl_empty_s", 32'(s_empty), 1);
    chk("fl_cnt_f", 32'(f_count), 0);
    chk("fl_empty_f", 32'(f_empty), 1);
    chk("fl_err_s", {30'd0, s_ovf, s_unf}, 0);
    chk("fl_err_f", {30'd0, f_ovf, f_unf}, 0);
    data_w = 8'h5A;
    push_both(8'h5A);
    step();
    req_w = 1'b0;
    chk("post_fl_cnt_s", 32'(s_count), 1);
    chk("post_fl_cnt_f", 32'(f_count), 1);
    step();
    step();
    chk("post_fl_data_f", 32'(f_data_r), 32'h5A);
    req_r = 1'b1;
    step();
    req_r = 1'b0;
    step();
    chk("post_fl_empty_s", 32'(s_empty), 1);
    chk("post_fl_empty_f", 32'(f_empty), 1);

    // asynchronous reset mid-burst at count 7
    for (int i = 0; i < 7; i++) begin
      data_w = 8'(8'h70 + i);
      req_w = 1'b1;
      push_both(8'(8'h70 + i));
      step();
    end
    chk("cnt7_s", 32'(s_count), 7);
    chk("cnt7_f", 32'(f_count), 7);
    data_w = 8'h77;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    req_w = 1'b0;
    s_exp_q.delete();
    f_exp_q.delete();
    step();
    reset_n = 1'b1;
    step();
    chk("arst_after_s", 32'(s_count), 0);
    chk("arst_after_f", 32'(f_count), 0);
    step();
    chk("left_s", 32'(s_exp_q.size()), 0);
    chk("left_f", 32'(f_exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
